fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Controller for the program-counter register in the instruction-fetch stage. It computes the PC register's next value (`pc_next` feeds the PC register's `pc_in`) and sequences fetches against instruction memory with a request/ready handshake. It handles hazard stalls, branch/jump redirects (including redirects that arrive while fetch is blocked) and halt. The PC register has no enable, so holding is done by driving `pc_next = pc_cur`.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address loaded after reset
- `PC_STEP`, 4, sequential increment in bytes

Ports:
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `pc_cur`  in  32  current PC register output
- `pc_next`  out  32  next PC value to the PC register input
- `imem_req`  out  1  fetch request at `pc_cur`
- `imem_ready`  in  1  instruction memory accepts/returns the word this cycle
- `stall`  in  1  hazard unit freezes fetch
- `branch_taken`  in  1  taken-branch redirect request
- `branch_target`  in  32  branch target
- `jump`  in  1  jump redirect request
- `jump_target`  in  32  jump target
- `halt`  in  1  stop fetching until reset
- `fetch_valid`  out  1  instruction at `pc_cur` accepted this cycle
- `redirect`  out  1  PC is being redirected this cycle (squash younger fetches)
- `halted`  out  1  sequencer in HALTED state

## Operation
- Registered state: 2-bit FSM, `pend_vld`, 32-bit `pend_tgt`. Outputs are combinational from state and inputs.
- `advance = (state==FETCH) & imem_ready & ~stall & ~halt`.
- New redirect: `branch_taken` (priority) else `jump`; target = `branch_target` / `jump_target`.
- Targets have bits [1:0] forced to 0. Sequential step is `pc_cur + PC_STEP`, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- BOOT (entered on reset):
  - `imem_req=0`, `pc_next=RESET_PC`, no pending.
  - Next state FETCH unconditionally.
- FETCH:
  - `imem_req=1`.
  - On `advance`:
    - `fetch_valid=1`.
    - `pc_next` = new redirect target if present, else `pend_tgt` if `pend_vld`, else sequential.
    - `redirect=1` when either redirect source is used.
    - `pend_vld` clears.
  - Not advancing:
    - `pc_next=pc_cur`.
    - A new redirect is captured into `pend_tgt` and sets `pend_vld`; the newest redirect overwrites an older pending one.
  - `halt`=1 (highest priority):
    - `imem_req=0`, `pc_next=pc_cur`.
    - Pending redirect discarded.
    - Next state HALTED.
- HALTED:
  - `imem_req=0`, `pc_next=pc_cur`, `halted=1`.
  - All inputs ignored; left only via reset.
- Encoding 2'b11 is unused and recovers to BOOT.

## Timing
- Reset values (`reset_n` low, asynchronous): state=BOOT, `pend_vld=0`, `pend_tgt=0`.
- Outputs during reset: `imem_req=0`, `fetch_valid=0`, `redirect=0`, `halted=0`, `pc_next=RESET_PC`.
- First `imem_req` is in the 2nd cycle after reset deassertion; `pc_cur` equals `RESET_PC` at that point.
- Redirect latency: target appears on `pc_cur` one edge after the advancing cycle. A redirect captured during a stall is applied on the first later advance.
- A redirect and `advance` in the same cycle take effect immediately and are not recorded as pending.
- `stall` and `imem_ready` are sampled only in FETCH. `imem_req` stays high while waiting; it never drops without `advance` or `halt`.
- Reset mid-wait or mid-halt returns to BOOT and clears the pending redirect.

## Structure
- Shared package `fetch_pkg`: FSM state encodings (BOOT=2'b00, FETCH=2'b01, HALTED=2'b10), `PC_STEP`, word-alignment mask.
- One sub-module, `next_pc_mux`: combinational selection among hold, sequential, pending and new redirect. The FSM and pending register stay in the top.

## Test plan
- Reset release with `RESET_PC=32'h0040_0000`, `imem_ready=1` → `pc_next`=0x00400000 in BOOT. `pc_cur` then steps 0x00400000, 0x00400004, 0x00400008, with `fetch_valid=1` each cycle.
- `imem_ready=0` for 3 cycles at pc 0x10 → `pc_next=0x10` and `imem_req=1` held for 3 cycles. On ready, `pc_next=0x14`.
- `stall=1` with `branch_taken=1`, target 0x203 for one cycle; stall continues 2 cycles → `pend_vld` set, `pc_next` holds. The first advance gives `pc_next=0x200` and `redirect=1`.
- `branch_taken` (0x100) and `jump` (0x300) in the same advancing cycle → `pc_next=0x100`. Pending stays clear.
- `pc_cur=32'hFFFF_FFFC`, advance → `pc_next=0`. Then `halt=1` → `imem_req=0`, `halted=1`, PC frozen. Reset pulse mid-halt → BOOT.
- Stall-captured jump (0x80), then `halt` before advance → pending discarded. After reset, fetch starts at `RESET_PC`, not 0x80.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch PC sequencer: FSM encodings,
// next-PC source selects, sequential step and word-alignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        SEL_RESET = 3'd0,
        SEL_HOLD  = 3'd1,
        SEL_SEQ   = 3'd2,
        SEL_PEND  = 3'd3,
        SEL_NEW   = 3'd4
    } pc_sel_t;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    // Redirect targets are always word addresses.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_mux.sv
// Combinational next-PC source selection: reset vector, hold, sequential
// step, pending redirect or a redirect arriving this cycle.
module next_pc_mux
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] SEQ_STEP = 32'd4
) (
    input  pc_sel_t     sel,
    input  logic [31:0] pc_cur,
    input  logic [31:0] pend_tgt,
    input  logic [31:0] new_tgt,
    output logic [31:0] pc_next
);

    logic [31:0] pc_seq;

    // 32-bit add wraps naturally, so the top word steps back to 0.
    assign pc_seq = pc_cur + SEQ_STEP;

    always_comb begin
        pc_next = pc_cur;
        case (sel)
            SEL_RESET: pc_next = RESET_PC;
            SEL_HOLD:  pc_next = pc_cur;
            SEL_SEQ:   pc_next = pc_seq;
            SEL_PEND:  pc_next = pend_tgt;
            SEL_NEW:   pc_next = new_tgt;
            default:   pc_next = pc_cur;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch PC controller: sequences fetches against imem with a
// request/ready handshake, holds on stalls and remembers blocked redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = fetch_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    output logic        fetch_valid,
    output logic        redirect,
    output logic        halted
);
    import fetch_pkg::*;

    state_t      state;
    logic        pend_vld;
    logic [31:0] pend_tgt;
    pc_sel_t     sel;
    logic        new_vld;
    logic [31:0] new_tgt;
    logic        advance;

    // Branch wins over jump when both are requested together.
    assign new_vld = branch_taken | jump;
    assign new_tgt = word_align(branch_taken ? branch_target : jump_target);
    assign advance = (state == ST_FETCH) & imem_ready & ~stall & ~halt;

    always_comb begin
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        redirect    = 1'b0;
        halted      = 1'b0;
        sel         = SEL_HOLD;
        case (state)
            ST_BOOT: sel = SEL_RESET;
            ST_FETCH: begin
                imem_req = ~halt;
                if (advance) begin
                    fetch_valid = 1'b1;
                    redirect    = new_vld | pend_vld;
                    if (new_vld)
                        sel = SEL_NEW;
                    else if (pend_vld)
                        sel = SEL_PEND;
                    else
                        sel = SEL_SEQ;
                end
            end
            ST_HALTED: halted = 1'b1;
            default:   sel = SEL_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_BOOT;
            pend_vld <= 1'b0;
            pend_tgt <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state    <= ST_FETCH;
                    pend_vld <= 1'b0;
                end
                ST_FETCH: begin
                    if (halt) begin
                        state    <= ST_HALTED;
                        pend_vld <= 1'b0;
                    end else if (advance) begin
                        pend_vld <= 1'b0;
                    end else if (new_vld) begin
                        // Newest blocked redirect replaces any older one.
                        pend_vld <= 1'b1;
                        pend_tgt <= new_tgt;
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default: begin
                    state    <= ST_BOOT;
                    pend_vld <= 1'b0;
                end
            endcase
        end
    end

    next_pc_mux #(
        .RESET_PC (RESET_PC),
        .SEQ_STEP (PC_STEP)
    ) u_next_pc_mux (
        .sel      (sel),
        .pc_cur   (pc_cur),
        .pend_tgt (pend_tgt),
        .new_tgt  (new_tgt),
        .pc_next  (pc_next)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Table-driven bench for fetch_sequencer; the bench itself models the PC
// register by feeding pc_next back into pc_cur on each rising edge.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        imem_req;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic        fetch_valid;
    logic        redirect;
    logic        halted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC (RST_PC),
        .PC_STEP  (32'd4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_cur        (pc_cur),
        .pc_next       (pc_next),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .fetch_valid   (fetch_valid),
        .redirect      (redirect),
        .halted        (halted)
    );

    typedef struct {
        string       name;
        logic        set_pc;
        logic [31:0] pc_val;
        logic        stall;
        logic        ready;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        halt;
        logic        req;
        logic        fv;
        logic        rd;
        logic        hl;
        logic [31:0] pcn;
    } vec_t;

    vec_t exp_q[$];
    vec_t tab[23];

    function automatic vec_t mk(input string name, input logic set_pc, input logic [31:0] pc_val,
                                input logic st, input logic rdy, input logic br, input logic [31:0] bt,
                                input logic jmp, input logic [31:0] jt, input logic hlt,
                                input logic req, input logic fv, input logic rd, input logic hl,
                                input logic [31:0] pcn);
        vec_t v;
        v.name = name; v.set_pc = set_pc; v.pc_val = pc_val;
        v.stall = st; v.ready = rdy; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt; v.halt = hlt;
        v.req = req; v.fv = fv; v.rd = rd; v.hl = hl; v.pcn = pcn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge; leaves just after the next one.
    task automatic cyc(input vec_t v);
        vec_t        e;
        logic [31:0] nxt;
        if (v.set_pc) pc_cur = v.pc_val;
        stall = v.stall; imem_ready = v.ready;
        branch_taken = v.br; branch_target = v.bt;
        jump = v.jmp; jump_target = v.jt; halt = v.halt;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({e.name, ".imem_req"},    {31'b0, imem_req},    {31'b0, e.req});
        chk({e.name, ".fetch_valid"}, {31'b0, fetch_valid}, {31'b0, e.fv});
        chk({e.name, ".redirect"},    {31'b0, redirect},    {31'b0, e.rd});
        chk({e.name, ".halted"},      {31'b0, halted},      {31'b0, e.hl});
        chk({e.name, ".pc_next"},     pc_next,              e.pcn);
        $display("txn %-14s pc_cur=%h pc_next=%h req=%b fv=%b rd=%b hl=%b",
                 e.name, pc_cur, pc_next, imem_req, fetch_valid, redirect, halted);
        nxt = pc_next;
        @(posedge clk);
        #1;
        pc_cur = nxt;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; imem_ready = 1'b1; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0; halt = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must react before any edge.
    task automatic reset_pulse(input string nm);
        reset_n = 1'b0;
        idle_inputs();
        #1;
        chk({nm, ".imem_req"},    {31'b0, imem_req},    32'd0);
        chk({nm, ".fetch_valid"}, {31'b0, fetch_valid}, 32'd0);
        chk({nm, ".redirect"},    {31'b0, redirect},    32'd0);
        chk({nm, ".halted"},      {31'b0, halted},      32'd0);
        chk({nm, ".pc_next"},     pc_next,              RST_PC);
        $display("txn %-14s reset asserted pc_next=%h halted=%b", nm, pc_next, halted);
        @(posedge clk);
        #1;
        pc_cur  = pc_next;
        reset_n = 1'b1;
    endtask

    initial begin
        tab[0]  = mk("boot",          0, 0,            0,1, 0,0,     0,0,     0, 0,0,0,0, RST_PC);
        tab[1]  = mk("seq0",          0, 0,            0,1, 0,0,     0,0,     0, 1,1,0,0, 32'h0040_0004);
        tab[2]  = mk("seq1",          0, 0,            0,1, 0,0,     0,0,     0, 1,1,0,0, 32'h0040_0008);
        tab[3]  = mk("seq2",          0, 0,            0,1, 0,0,     0,0,     0, 1,1,0,0, 32'h0040_000C);
        tab[4]  = mk("wait0",         1, 32'h10,       0,0, 0,0,     0,0,     0, 1,0,0,0, 32'h10);
        tab[5]  = mk("wait1",         0, 0,            0,0, 0,0,     0,0,     0, 1,0,0,0, 32'h10);
        tab[6]  = mk("wait2",         0, 0,            0,0, 0,0,     0,0,     0, 1,0,0,0, 32'h10);
        tab[7]  = mk("ready",         0, 0,            0,1, 0,0,     0,0,     0, 1,1,0,0, 32'h14);
        tab[8]  = mk("stall_br",      0, 0,            1,1, 1,32'h203, 0,0,   0, 1,0,0,0, 32'h14);
        tab[9]  = mk("stall1",        0, 0,            1,1, 0,0,     0,0,     0, 1,0,0,0, 32'h14);
        tab[10] = mk("stall2",        0, 0,            1,1, 0,0,     0,0,     0, 1,0,0,0, 32'h14);
        tab[11] = mk("pend_apply",    0, 0,            0,1, 0,0,     0,0,     0, 1,1,1,0, 32'h200);
        tab[12] = mk("br_vs_jmp",     0, 0,            0,1, 1,32'h100, 1,32'h300, 0, 1,1,1,0, 32'h100);
        tab[13] = mk("no_pend_stall", 0, 0,            1,1, 0,0,     0,0,     0, 1,0,0,0, 32'h100);
        tab[14] = mk("no_pend_adv",   0, 0,            0,1, 0,0,     0,0,     0, 1,1,0,0, 32'h104);
        tab[15] = mk("jmp_align",     0, 0,            0,1, 0,0,     1,32'h302, 0, 1,1,1,0, 32'h300);
        tab[16] = mk("wait_jmp",      0, 0,            0,0, 0,0,     1,32'h500, 0, 1,0,0,0, 32'h300);
        tab[17] = mk("wait_br",       0, 0,            0,0, 1,32'h600, 0,0,   0, 1,0,0,0, 32'h300);
        tab[18] = mk("newest_pend",   0, 0,            0,1, 0,0,     0,0,     0, 1,1,1,0, 32'h600);
        tab[19] = mk("wrap",          1, 32'hFFFF_FFFC,0,1, 0,0,     0,0,     0, 1,1,0,0, 32'h0);
        tab[20] = mk("halt",          0, 0,            1,1, 0,0,     0,0,     1, 0,0,0,0, 32'h0);
        tab[21] = mk("halted0",       0, 0,            0,1, 1,32'h700, 0,0,   0, 0,0,0,1, 32'h0);
        tab[22] = mk("halted1",       0, 0,            0,1, 0,0,     1,32'h800, 1, 0,0,0,1, 32'h0);

        reset_n = 1'b0;
        pc_cur  = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.imem_req",    {31'b0, imem_req},    32'd0);
        chk("rst.fetch_valid", {31'b0, fetch_valid}, 32'd0);
        chk("rst.redirect",    {31'b0, redirect},    32'd0);
        chk("rst.halted",      {31'b0, halted},      32'd0);
        chk("rst.pc_next",     pc_next,              RST_PC);
        $display("txn %-14s pc_next=%h", "reset", pc_next);
        @(posedge clk);
        #1;
        pc_cur  = pc_next;
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) cyc(tab[i]);

        // Reset while halted returns to BOOT and fetch restarts at RESET_PC.
        reset_pulse("rst_mid_halt");
        cyc(mk("A.boot",   0,0, 0,1, 0,0, 0,0, 0, 0,0,0,0, RST_PC));
        cyc(mk("A.fetch",  0,0, 0,1, 0,0, 0,0, 0, 1,1,0,0, 32'h0040_0004));

        // Stall-captured jump, then halt before any advance; reset afterwards.
        cyc(mk("B.stall_j", 0,0, 1,1, 0,0, 1,32'h80, 0, 1,0,0,0, 32'h0040_0004));
        cyc(mk("B.halt",    0,0, 0,1, 0,0, 0,0,      1, 0,0,0,0, 32'h0040_0004));
        cyc(mk("B.halted",  0,0, 0,1, 0,0, 0,0,      0, 0,0,0,1, 32'h0040_0004));
        reset_pulse("rst_after_halt");
        cyc(mk("B.boot",    0,0, 0,1, 0,0, 0,0,      0, 0,0,0,0, RST_PC));
        cyc(mk("B.fetch",   0,0, 0,1, 0,0, 0,0,      0, 1,1,0,0, 32'h0040_0004));

        // Reset during a ready wait with a redirect pending clears it.
        cyc(mk("C.wait_j",  0,0, 0,0, 0,0, 1,32'h90, 0, 1,0,0,0, 32'h0040_0004));
        reset_pulse("rst_mid_wait");
        cyc(mk("C.boot",    0,0, 0,1, 0,0, 0,0,      0, 0,0,0,0, RST_PC));
        cyc(mk("C.fetch",   0,0, 0,1, 0,0, 0,0,      0, 1,1,0,0, 32'h0040_0004));
        cyc(mk("C.fetch2",  0,0, 0,1, 0,0, 0,0,      0, 1,1,0,0, 32'h0040_0008));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
